game_state_controller: RTL and testbench

- Master game state machine; sits directly downstream of the score/timer counter.
- Consumes that counter's SCORE_WIN, WIN and LOST flags plus the snake collision flag.
- Produces the 2-bit MSM_STATE and a latched timed-mode flag, which feed back to the score counter, snake control and VGA colour logic.
- Debounces the start button, latches game mode, pulses a score-counter reset at game start, and holds the WIN/LOST screens for a minimum time.

---
 rtl/game_state_controller.sv | 194 +++++++++++++++++++
 tb/tb_game_state_controller.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// Master game FSM: debounced start/pause buttons, mode latch, win/lose hold screens.
// Latency: clean button press -> state change after DEBOUNCE_CYCLES+3 edges; flags act next edge.
// Backpressure: none; presses arriving while they cannot be honoured are dropped, not queued.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   BTN_START             raw start/restart button (asynchronous)
//   TIMED_SW              mode switch, sampled only when a game starts
//   COLLISION, SCORE_WIN, TIMER_WIN, TIMER_LOST  game outcome flags (levels)
//   MSM_STATE             0 IDLE, 1 PLAY, 2 WIN, 3 LOST (registered)
//   TIMED_MODE            mode latched at game start
//   SCORE_RESET           one-cycle pulse clearing the score/timer counters
// Optional build macro PAUSE_EN adds BTN_PAUSE (raw pause button) and PAUSED.
`timescale 1ns/1ps

module game_state_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 200000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_START,
`ifdef PAUSE_EN
  input  logic       BTN_PAUSE,
  output logic       PAUSED,
`endif
  input  logic       TIMED_SW,
  input  logic       COLLISION,
  input  logic       SCORE_WIN,
  input  logic       TIMER_WIN,
  input  logic       TIMER_LOST,
  output logic [1:0] MSM_STATE,
  output logic       TIMED_MODE,
  output logic       SCORE_RESET
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

`ifdef PAUSE_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOST = 2'd3
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_press;

  assign btn_raw[0] = BTN_START;
`ifdef PAUSE_EN
  assign btn_raw[1] = BTN_PAUSE;
`endif

  // One synchroniser + debouncer per button. The press pulse is taken from a
  // delayed copy of the debounced level so it lands one cycle after the level flips.
  for (genvar i = 0; i < NB; i++) begin : g_btn
    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic          press;
    logic [DW-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        sync_a  <= 1'b0;
        sync_b  <= 1'b0;
        level   <= 1'b0;
        level_d <= 1'b0;
        press   <= 1'b0;
        cnt     <= '0;
      end else begin
        sync_a  <= btn_raw[i];
        sync_b  <= sync_a;
        if (sync_b == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt   <= '0;
          level <= sync_b;
        end else begin
          cnt <= cnt + 1'b1;
        end
        level_d <= level;
        press   <= level & ~level_d;
      end
    end

    assign btn_press[i] = press;
  end

  logic start_press;
  assign start_press = btn_press[0];
`ifdef PAUSE_EN
  logic pause_press;
  assign pause_press = btn_press[1];
`endif

  state_t        state;
  logic [1:0]    msm_q;
  logic          timed_q;
  logic          score_reset_q;
  logic          paused_q;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  // Hold counter idles at zero outside WIN/LOST, so it starts from zero on entry
  // and saturates instead of wrapping.
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt <= '0;
    end else if (state == S_WIN || state == S_LOST) begin
      if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // msm_q mirrors the state except while paused, when it reads IDLE so the
  // downstream timer and snake freeze.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= S_IDLE;
      msm_q         <= S_IDLE;
      timed_q       <= 1'b0;
      score_reset_q <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      score_reset_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_press) begin
            state         <= S_PLAY;
            msm_q         <= S_PLAY;
            timed_q       <= TIMED_SW;
            score_reset_q <= 1'b1;
          end
        end
        S_PLAY: begin
`ifdef PAUSE_EN
          if (paused_q) begin
            if (pause_press) begin
              paused_q <= 1'b0;
              msm_q    <= S_PLAY;
            end
          end else
`endif
          // Loss is checked first so a simultaneous win and loss resolves to LOST.
          if (COLLISION || (timed_q && TIMER_LOST)) begin
            state <= S_LOST;
            msm_q <= S_LOST;
          end else if ((timed_q && TIMER_WIN) || (!timed_q && SCORE_WIN)) begin
            state <= S_WIN;
            msm_q <= S_WIN;
          end
`ifdef PAUSE_EN
          else if (pause_press) begin
            paused_q <= 1'b1;
            msm_q    <= S_IDLE;
          end
`endif
        end
        default: begin
          if (start_press && hold_done) begin
            state    <= S_IDLE;
            msm_q    <= S_IDLE;
            paused_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign MSM_STATE   = msm_q;
  assign TIMED_MODE  = timed_q;
  assign SCORE_RESET = score_reset_q;
`ifdef PAUSE_EN
  assign PAUSED      = paused_q;
`else
  logic unused_paused;
  assign unused_paused = paused_q;
`endif

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Reference model works on a raw-sample history window and edge counts.
`timescale 1ns/1ps

module tb_game_state_controller;
  localparam int D = 4;
  localparam int H = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic BTN_START = 1'b0;
  logic TIMED_SW = 1'b0;
  logic COLLISION = 1'b0;
  logic SCORE_WIN = 1'b0;
  logic TIMER_WIN = 1'b0;
  logic TIMER_LOST = 1'b0;
  logic [1:0] MSM_STATE;
  logic TIMED_MODE;
  logic SCORE_RESET;
`ifdef PAUSE_EN
  logic BTN_PAUSE = 1'b0;
  logic PAUSED;
`endif

  game_state_controller #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .BTN_START(BTN_START),
`ifdef PAUSE_EN
    .BTN_PAUSE(BTN_PAUSE),
    .PAUSED(PAUSED),
`endif
    .TIMED_SW(TIMED_SW),
    .COLLISION(COLLISION),
    .SCORE_WIN(SCORE_WIN),
    .TIMER_WIN(TIMER_WIN),
    .TIMER_LOST(TIMER_LOST),
    .MSM_STATE(MSM_STATE),
    .TIMED_MODE(TIMED_MODE),
    .SCORE_RESET(SCORE_RESET)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state
  logic [63:0] m_hist [2];   // raw button samples, bit 0 = newest edge
  bit   m_level [2];         // accepted (debounced) button level
  bit   m_p1 [2];
  bit   m_p2 [2];
  int   m_state;             // 0 idle, 1 play, 2 win, 3 lost
  bit   m_timed;
  bit   m_sreset;
  bit   m_paused;
  int   m_edge;
  int   m_entry;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_hist[b]  = '0;
      m_level[b] = 1'b0;
      m_p1[b]    = 1'b0;
      m_p2[b]    = 1'b0;
    end
    m_state  = 0;
    m_timed  = 1'b0;
    m_sreset = 1'b0;
    m_paused = 1'b0;
    m_edge   = 0;
    m_entry  = 0;
  endtask

  // A level is accepted once the synchronised button (raw delayed two edges)
  // has disagreed with the accepted level for D edges in a row. The game
  // sees the rising-edge press two edges after acceptance.
  task automatic model_btn(input int b, input bit raw, output bit press);
    bit all_diff;
    press   = m_p2[b];
    m_p2[b] = m_p1[b];
    m_p1[b] = 1'b0;
    m_hist[b] = {m_hist[b][62:0], raw};
    all_diff = 1'b1;
    for (int k = 2; k <= D + 1; k++)
      if (m_hist[b][k] == m_level[b]) all_diff = 1'b0;
    if (all_diff) begin
      m_level[b] = ~m_level[b];
      if (m_level[b]) m_p1[b] = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit sp;
    bit pp;
    model_btn(0, BTN_START, sp);
`ifdef PAUSE_EN
    model_btn(1, BTN_PAUSE, pp);
`else
    pp = 1'b0;
`endif
    m_edge++;
    m_sreset = 1'b0;
    case (m_state)
      0: if (sp) begin
        m_state  = 1;
        m_timed  = TIMED_SW;
        m_sreset = 1'b1;
      end
      1: begin
        if (m_paused) begin
          if (pp) m_paused = 1'b0;
        end else if (COLLISION || (m_timed && TIMER_LOST)) begin
          m_state = 3; m_entry = m_edge;
        end else if (m_timed ? TIMER_WIN : SCORE_WIN) begin
          m_state = 2; m_entry = m_edge;
        end else if (pp) begin
          m_paused = 1'b1;
        end
      end
      default: if (sp && (m_edge - m_entry >= H)) m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check("msm_state", MSM_STATE, m_paused ? 2'd0 : 2'(m_state));
    check("timed_mode", {1'b0, TIMED_MODE}, {1'b0, m_timed});
    check("score_reset", {1'b0, SCORE_RESET}, {1'b0, m_sreset});
`ifdef PAUSE_EN
    check("paused", {1'b0, PAUSED}, {1'b0, m_paused});
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Clean press then clean release; the press is consumed on the (D+4)th edge.
  task automatic press_start();
    BTN_START = 1'b1;
    run(D + 4);
    BTN_START = 1'b0;
    run(D + 4);
  endtask

  bit sr_seen;
  bit btn_lvl;
  int btn_left;
`ifdef PAUSE_EN
  bit pbtn_lvl;
  int pbtn_left;
`endif

  initial begin
    model_reset();
    RESET_N = 1'b0;
    #12;
    check("reset_msm", MSM_STATE, 2'd0);
    check("reset_timed", {1'b0, TIMED_MODE}, 2'd0);
    check("reset_sreset", {1'b0, SCORE_RESET}, 2'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Start, untimed: first sampled at edge 0, PLAY after edge 7
    TIMED_SW  = 1'b0;
    BTN_START = 1'b1;
    run(7);
    check("start_not_yet", MSM_STATE, 2'd0);
    step();
    check("start_play", MSM_STATE, 2'd1);
    check("start_sreset", {1'b0, SCORE_RESET}, 2'd1);
    check("start_untimed", {1'b0, TIMED_MODE}, 2'd0);
    step();
    check("sreset_one_cycle", {1'b0, SCORE_RESET}, 2'd0);
    BTN_START = 1'b0;
    run(D + 4);

    // Untimed win; press completing inside the hold window is dropped
    BTN_START = 1'b1;
    run(2);
    SCORE_WIN = 1'b1;
    step();
    SCORE_WIN = 1'b0;
    check("untimed_win", MSM_STATE, 2'd2);
    run(6);
    check("early_press_dropped", MSM_STATE, 2'd2);
    BTN_START = 1'b0;
    run(D + 4);
    check("still_win", MSM_STATE, 2'd2);
    press_start();
    check("hold_done_to_idle", MSM_STATE, 2'd0);

    // Timed game: mode latch, SCORE_WIN ignored, loss beats win
    TIMED_SW = 1'b1;
    press_start();
    check("timed_play", MSM_STATE, 2'd1);
    check("timed_latched", {1'b0, TIMED_MODE}, 2'd1);
    TIMED_SW = 1'b0;
    step();
    check("timed_sw_ignored", {1'b0, TIMED_MODE}, 2'd1);
    SCORE_WIN = 1'b1;
    run(3);
    SCORE_WIN = 1'b0;
    check("timed_score_win_ignored", MSM_STATE, 2'd1);
    TIMER_WIN = 1'b1;
    COLLISION = 1'b1;
    step();
    TIMER_WIN = 1'b0;
    COLLISION = 1'b0;
    check("collision_beats_win", MSM_STATE, 2'd3);
    run(H + 2);
    press_start();
    check("lost_to_idle", MSM_STATE, 2'd0);

    // Asynchronous reset between clock edges, mid-game
    TIMED_SW = 1'b1;
    press_start();
    check("reset_game_play", MSM_STATE, 2'd1);
    #3;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("areset_msm", MSM_STATE, 2'd0);
    check("areset_timed", {1'b0, TIMED_MODE}, 2'd0);
    #2;
    RESET_N  = 1'b1;
    TIMED_SW = 1'b0;
    run(10);
    check("idle_after_reset", MSM_STATE, 2'd0);

    // Bounce rejection: 3 high / 2 low, five times
    sr_seen = 1'b0;
    repeat (5) begin
      BTN_START = 1'b1;
      repeat (3) begin step(); sr_seen |= SCORE_RESET; end
      BTN_START = 1'b0;
      repeat (2) begin step(); sr_seen |= SCORE_RESET; end
    end
    run(D + 4);
    check("bounce_no_sreset", {1'b0, sr_seen}, 2'd0);
    check("bounce_idle", MSM_STATE, 2'd0);

`ifdef PAUSE_EN
    // Pause freezes the visible state and masks outcome flags
    press_start();
    BTN_PAUSE = 1'b1;
    run(D + 4);
    check("pause_on", {1'b0, PAUSED}, 2'd1);
    check("pause_msm", MSM_STATE, 2'd0);
    BTN_PAUSE = 1'b0;
    run(D + 4);
    COLLISION = 1'b1;
    run(3);
    COLLISION = 1'b0;
    check("pause_ignores_collision", MSM_STATE, 2'd0);
    BTN_PAUSE = 1'b1;
    run(D + 4);
    check("pause_off", {1'b0, PAUSED}, 2'd0);
    check("resume_msm", MSM_STATE, 2'd1);
    BTN_PAUSE = 1'b0;
    run(D + 4);
    COLLISION = 1'b1;
    step();
    COLLISION = 1'b0;
    check("resume_collision", MSM_STATE, 2'd3);
    run(H + 2);
    press_start();
    pbtn_left = 0;
    pbtn_lvl  = 1'b0;
`endif

    // Randomised run against the model
    btn_left = 0;
    btn_lvl  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        btn_lvl  = 1'($urandom_range(0, 1));
        btn_left = int'($urandom_range(1, 12));
      end
      btn_left--;
      BTN_START  = btn_lvl;
      TIMED_SW   = 1'($urandom_range(0, 1));
      COLLISION  = ($urandom_range(0, 39) == 0);
      SCORE_WIN  = ($urandom_range(0, 19) == 0);
      TIMER_WIN  = ($urandom_range(0, 29) == 0);
      TIMER_LOST = ($urandom_range(0, 29) == 0);
`ifdef PAUSE_EN
      if (pbtn_left == 0) begin
        pbtn_lvl  = 1'($urandom_range(0, 1));
        pbtn_left = int'($urandom_range(1, 14));
      end
      pbtn_left--;
      BTN_PAUSE = pbtn_lvl;
`endif
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
